// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the ordered reset-release sequencer.
// Optional acknowledge timeout is enabled with RSTSEQ_TIMEOUT_EN.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT,
    RELEASE,
    WAIT_DONE,
    READY,
    FAULT
  } state_t;

  localparam int HOLD_DEF    = 16;
  localparam int GAP_DEF     = 4;
  localparam int TIMEOUT_DEF = 1024;

  function automatic int stage_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sized so the largest terminal count fits without wrapping.
  function automatic int cnt_w(input int h, input int g, input int t);
    int m;
    m = (h > g) ? h : g;
    m = (m > t) ? m : t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable up-counter with terminal-count compare, shared by all
// sequencer states.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release: hold, then free each stage after a gap and ack.
// Define RSTSEQ_TIMEOUT_EN to add the acknowledge timeout and FAULT state.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = HOLD_DEF,
  parameter int GAP_CYCLES     = GAP_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int STAGE_W        = stage_w(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rst_req_n,
  input  logic [NUM_STAGES-1:0] init_done,
  output logic [NUM_STAGES-1:0] sub_reset,
  output logic                  sys_ready,
  output logic [STAGE_W-1:0]    cur_stage,
  output logic                  fault
);

  localparam int CNT_W =
    cnt_w(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

`ifdef RSTSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   term;
  logic               tc;
  logic               clr;
  logic               en;
  logic               ack;
  logic               last;
  logic [STAGE_W-1:0] nxt;

  assign ack  = init_done[cur_stage];
  assign last = (cur_stage == STAGE_W'(NUM_STAGES - 1));
  assign nxt  = cur_stage + 1'b1;

  // Timer is cleared on every state change so it never wraps.
  always_comb begin
    term = '0;
    en   = 1'b0;
    clr  = 1'b0;
    case (state)
      ASSERT: begin
        term = CNT_W'(HOLD_CYCLES - 1);
        en   = 1'b1;
        clr  = tc;
      end
      RELEASE: begin
        term = CNT_W'(GAP_CYCLES - 1);
        en   = 1'b1;
        clr  = tc;
      end
      WAIT_DONE: begin
        term = CNT_W'(TIMEOUT_CYCLES - 1);
        en   = TO_EN;
        clr  = ack | tc;
      end
      default: ;
    endcase
    if (!rst_req_n) clr = 1'b1;
  end

  rst_seq_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(clr),
    .en   (en),
    .term (term),
    .count(count),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (reset || !rst_req_n) begin
      state     <= ASSERT;
      sub_reset <= '1;
      sys_ready <= 1'b0;
      cur_stage <= '0;
    end else begin
      case (state)
        ASSERT: begin
          if (tc) begin
            state        <= RELEASE;
            sub_reset[0] <= 1'b0;
          end
        end
        RELEASE: begin
          if (tc) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (ack) begin
            if (last) begin
              state     <= READY;
              sys_ready <= 1'b1;
            end else begin
              state          <= RELEASE;
              cur_stage      <= nxt;
              sub_reset[nxt] <= 1'b0;
            end
          end
`ifdef RSTSEQ_TIMEOUT_EN
          else if (tc) begin
            state     <= FAULT;
            sub_reset <= '1;
            sys_ready <= 1'b0;
          end
`endif
        end
        READY: ;
`ifdef RSTSEQ_TIMEOUT_EN
        FAULT: ;
`endif
        default: state <= ASSERT;
      endcase
    end
  end

`ifdef RSTSEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset || !rst_req_n) begin
      fault <= 1'b0;
    end else if (state == WAIT_DONE && !ack && tc) begin
      fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Ordered reset-release controller for the BCD ALU system.
- Input: the debounced, active-low reset request produced by the system reset handler.
- Holds all subsystem resets (keypad/input, ALU core, display) asserted, then releases them one stage at a time. Each stage waits a fixed gap and for that subsystem's init-done acknowledge before the next stage is released.
- Raises sys_ready once every stage is up.

Parameters:
- NUM_STAGES, 3, number of sequenced subsystems (legal 1..8); stage 0 is released first.
- HOLD_CYCLES, 16, cycles all resets are held after the request is released (legal ≥1).
- GAP_CYCLES, 4, cycles spent in RELEASE for each stage before its acknowledge is checked (legal ≥1).
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for an acknowledge; used only with the optional feature.

Ports:
- clk, input, 1, system clock (120 MHz).
- reset, input, 1, synchronous active-high reset; sampled only on the rising edge of clk.
- rst_req_n, input, 1, debounced reset request, active low; already synchronous to clk.
- init_done, input, NUM_STAGES, per-stage acknowledge, high when that subsystem has finished initialising.
- sub_reset, output, NUM_STAGES, per-stage reset, active high.
- sys_ready, output, 1, high when all stages are released and acknowledged.
- cur_stage, output, STAGE_W = max(1,clog2(NUM_STAGES)), index of the stage currently being released.
- fault, output, 1, acknowledge-timeout flag.

Behaviour:
- Reset values:
  - sub_reset = all ones; sys_ready = 0; cur_stage = 0; fault = 0.
  - State = ASSERT; internal counter = 0.
- Priority order: reset, then rst_req_n low, then normal state transitions.
- rst_req_n low, in any state: next edge gives state ASSERT, counter 0, cur_stage 0, sub_reset all ones, sys_ready 0, fault 0. The block stays in ASSERT with the counter frozen at 0 while rst_req_n stays low.
- States:
  - ASSERT: counter increments each cycle. On the edge where counter == HOLD_CYCLES-1: go to RELEASE, clear sub_reset[0] on that same edge, reset the counter.
  - RELEASE: counter counts 0..GAP_CYCLES-1. On the last count: go to WAIT_DONE, reset the counter.
  - WAIT_DONE: init_done[cur_stage] is sampled each cycle. When it is high:
    - If cur_stage == NUM_STAGES-1: go to READY and set sys_ready on that edge.
    - Otherwise: increment cur_stage, clear sub_reset[new stage] on that edge, re-enter RELEASE.
  - READY: outputs are held. init_done changes are ignored.
  - FAULT: only reachable with the optional feature.
- Cleared sub_reset bits stay cleared until the next ASSERT entry. Bits are cleared strictly in ascending index order.
- init_done bits for stages not yet being waited on are ignored, including if they are already high.
- Timing with init_done tied high:
  - sub_reset[k] falls on edge HOLD_CYCLES + k*(GAP_CYCLES+1) after reset deasserts, given rst_req_n high.
  - sys_ready rises on edge HOLD_CYCLES + NUM_STAGES*(GAP_CYCLES+1).
  - Defaults: sub_reset[0] at 16, [1] at 21, [2] at 26; sys_ready at 31.
- The counter is wide enough for max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) and never wraps: it is cleared on every state transition.

Optional Feature:
- Macro: RSTSEQ_TIMEOUT_EN.
- Defined:
  - The WAIT_DONE counter runs. If counter == TIMEOUT_CYCLES-1 and init_done[cur_stage] is low, the next edge enters FAULT: fault = 1, sub_reset = all ones, sys_ready = 0.
  - An acknowledge arriving in that same final cycle wins; no fault is raised.
  - FAULT is left only by reset, or by rst_req_n low, which enters ASSERT and clears fault.
- Undefined: WAIT_DONE waits indefinitely, fault is tied to 0, and the FAULT state is not built.

Decomposition:
- Package rst_seq_pkg holds:
  - The state enum (ASSERT, RELEASE, WAIT_DONE, READY, FAULT).
  - Default constants for HOLD, GAP and TIMEOUT.
  - The STAGE_W computation function.
- One sub-module, rst_seq_timer: a clearable up-counter with a terminal-count compare input and a tc flag output, instantiated once and shared by all states.

Test Plan:
- Defaults, init_done = 3'b111, rst_req_n high after reset -> sub_reset 111→110 at edge 16, →100 at 21, →000 at 26; sys_ready = 1 at edge 31; cur_stage 0,1,2.
- init_done[1] held low until edge 40 -> sub_reset stays 100 and sys_ready stays 0; after init_done[1] rises, sub_reset[2] falls one edge later and sys_ready rises GAP_CYCLES+1 edges after that.
- rst_req_n pulsed low for 1 cycle while in READY -> next edge: sub_reset = 111, sys_ready = 0, cur_stage = 0; full sequence repeats with the same 16/21/26/31 timing measured from rst_req_n returning high.
- reset asserted mid-RELEASE of stage 1 while rst_req_n is also low -> outputs return to reset values on the next edge; no bit of sub_reset[2:1] ever clears out of order.
- With RSTSEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES = 8, init_done[0] stuck low -> fault = 1 and sub_reset = 111 exactly 8 cycles after WAIT_DONE entry; driving rst_req_n low clears fault.
- Same setup, init_done[0] rising in cycle 7 of WAIT_DONE -> no fault; stage 1 is released.
